sprite_draw_engine: RTL
=======================

Name: sprite_draw_engine

Overview:
- Handshake-driven responder that accepts sprite draw/erase commands from the game FSM and emits one pixel per clock to the VGA adapter plot interface (x, y, colour, plot).
- Replaces the game FSM's fixed-delay draw waits with an explicit req/busy/done protocol.
- Sits between the game FSM (initiator) and vga_adapter (pixel sink) in the 160x120, 3-bit-colour display path.

Parameters:
- PRESS_SIZE, 36, press sprite edge length in pixels (square); legal range 1..63
- GARB_SIZE, 20, garbage sprite edge length in pixels (square); legal range 1..63
- LANE_PITCH, 40, horizontal spacing between lane origins
- PRESS_XOFF, 2, press x offset inside its lane
- GARB_XOFF, 10, garbage x offset inside its lane
- PRESS_Y, 10, press sprite top row
- GARB_Y, 90, garbage sprite top row
- PRESS_COLOUR, 3'b111, press fill colour
- GARB_COLOUR, 3'b010, garbage fill colour

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  1  command request; sampled only while busy=0
- item  in  1  sprite select: 1 = press, 0 = garbage
- erase  in  1  1 = fill with black (3'b000), 0 = fill with the sprite colour
- position  in  3  press phase 0..5, or garbage lane 0..3
- busy  out  1  command in progress; req is ignored while high
- done  out  1  one-cycle pulse when the command completes
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  pixel colour
- plot  out  1  pixel write enable to vga_adapter

Behaviour:
- Reset: reset_n is synchronous, active-low, on CLOCK_50. On reset: state=IDLE, busy=0, done=0, plot=0, x=0, y=0, colour=0.
- Reset mid-command aborts the command immediately: no further plot pulses and no done pulse.
- States and transitions:
  - IDLE -> DRAW on req=1.
  - IDLE -> DONE on req=1 with an invalid position.
  - DRAW -> DONE after the last pixel.
  - DONE -> IDLE unconditionally.
- Accept cycle T (IDLE, req=1): item, erase and position are latched. Later changes to these inputs have no effect on the current command.
- Lane mapping for press:
  - lane = position for positions 0..3.
  - lane = 6 - position for positions 4..5, so 4->2 and 5->1.
  - Positions 6 and 7 are invalid.
- Lane mapping for garbage:
  - lane = position for positions 0..3.
  - Positions 4..7 are invalid; 3'b111 means "no garbage".
- Origin:
  - Press: ox = lane*LANE_PITCH + PRESS_XOFF, oy = PRESS_Y.
  - Garbage: ox = lane*LANE_PITCH + GARB_XOFF, oy = GARB_Y.
- DRAW timing:
  - Runs cycles T+1 .. T+N*N, where N = PRESS_SIZE or GARB_SIZE.
  - Raster order is row-major: col counts 0..N-1 and wraps to 0 while row increments.
  - Output per cycle: x = ox+col, y = oy+row, plot = 1.
  - colour = 3'b000 if erase, else the sprite colour.
- Clipping: a pixel with x > 159 or y > 119 drives plot=0 in its cycle but still consumes that cycle. Total DRAW length stays N*N.
- Arithmetic: col and row counters are 6 bits wide. x is computed at 9 bits and y at 8 bits before the clip compare, then truncated to the port widths.
- DONE cycle (T+N*N+1): done=1, busy=1, plot=0.
- busy timing:
  - busy=1 from T+1 through the DONE cycle inclusive.
  - busy=0 and done=0 in IDLE.
  - The earliest next accept is the cycle after DONE.
- Invalid position: no pixels are written. DONE occurs at T+1, so done pulses at T+1.
- req held high continuously: a new command is accepted on every IDLE cycle, giving back-to-back commands with exactly one IDLE gap.
- plot=0 in every state other than DRAW.

Test Plan:
1. Reset, then req=1, item=1, erase=0, position=0 at T -> plot high T+1..T+1296; first pixel (2,10), last pixel (37,45), colour 3'b111; done pulse at T+1297; busy low at T+1298.
2. item=0, erase=1, position=3 -> 400 plots covering x 130..149, y 90..109, colour 3'b000; done at T+401.
3. Press position=5 and position=1 -> identical pixel sequences with x origin 42; position=4 -> x origin 82.
4. Garbage position=3'b111 -> zero plot cycles; done at T+1; busy high only at T+1.
5. Assert req and toggle position during a DRAW -> extra req ignored, pixels unchanged, exactly one done pulse; reset_n=0 at pixel 500 -> plot=0 and busy=0 on the next cycle, and no done pulse follows.
6. Override PRESS_XOFF=140, item=1, position=0 -> pixels with x > 159 have plot=0 while DRAW length remains 1296 cycles.

Source files
------------

// File: rtl/sprite_draw_if.sv
// Command/pixel bundle between the game FSM, the sprite draw engine and the
// VGA adapter plot port.
interface sprite_draw_if;
    logic       req;
    logic       item;
    logic       erase;
    logic [2:0] position;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output req, item, erase, position,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  req, item, erase, position,
        output busy, done, x, y, colour, plot
    );
endinterface

// File: rtl/sprite_draw_engine.sv
// Sprite draw engine: accepts a draw/erase command for a press or garbage
// sprite and rasterises a filled square, one pixel per clock, onto the
// 160x120 plot port. All outputs are registered.
module sprite_draw_engine #(
    parameter int          PRESS_SIZE   = 36,
    parameter int          GARB_SIZE    = 20,
    parameter int          LANE_PITCH   = 40,
    parameter int          PRESS_XOFF   = 2,
    parameter int          GARB_XOFF    = 10,
    parameter int          PRESS_Y      = 10,
    parameter int          GARB_Y       = 90,
    parameter logic [2:0]  PRESS_COLOUR = 3'b111,
    parameter logic [2:0]  GARB_COLOUR  = 3'b010
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    sprite_draw_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] PITCH_C  = 9'(LANE_PITCH);
    localparam logic [8:0] PXOFF_C  = 9'(PRESS_XOFF);
    localparam logic [8:0] GXOFF_C  = 9'(GARB_XOFF);
    localparam logic [7:0] PY_C     = 8'(PRESS_Y);
    localparam logic [7:0] GY_C     = 8'(GARB_Y);
    localparam logic [5:0] PSIZE_C  = 6'(PRESS_SIZE);
    localparam logic [5:0] GSIZE_C  = 6'(GARB_SIZE);

    state_t     state_r, state_s;
    logic [5:0] col_r, col_s, row_r, row_s, n_r, n_s;
    logic [8:0] ox_r, ox_s;
    logic [7:0] oy_r, oy_s;
    logic [2:0] fill_r, fill_s;
    logic       busy_r, busy_s, done_r, done_s, plot_r, plot_s;
    logic [7:0] x_r, x_s;
    logic [6:0] y_r, y_s;
    logic [2:0] colour_r, colour_s;

    logic [1:0] lane_s;
    logic       valid_s;
    logic [8:0] acc_ox_s;
    logic [7:0] acc_oy_s;
    logic [5:0] acc_n_s;
    logic [2:0] acc_fill_s;
    logic       pix_en_s;
    logic [8:0] px_s;
    logic [7:0] py_s;

    // Decode the live command inputs into lane, origin, size and fill colour.
    always_comb begin
        lane_s  = 2'd0;
        valid_s = 1'b0;
        if (bus.position <= 3'd3) begin
            lane_s  = bus.position[1:0];
            valid_s = 1'b1;
        end else if (bus.item && (bus.position <= 3'd5)) begin
            // Press phases 4 and 5 swing back towards the left lanes.
            lane_s  = 2'(3'd6 - bus.position);
            valid_s = 1'b1;
        end else begin
            lane_s  = 2'd0;
            valid_s = 1'b0;
        end
        acc_ox_s   = (9'(lane_s) * PITCH_C) + (bus.item ? PXOFF_C : GXOFF_C);
        acc_oy_s   = bus.item ? PY_C : GY_C;
        acc_n_s    = bus.item ? PSIZE_C : GSIZE_C;
        acc_fill_s = bus.erase ? 3'b000 : (bus.item ? PRESS_COLOUR : GARB_COLOUR);
    end

    // Next-state, raster counter and next-output logic.
    always_comb begin
        state_s  = state_r;
        col_s    = col_r;
        row_s    = row_r;
        n_s      = n_r;
        ox_s     = ox_r;
        oy_s     = oy_r;
        fill_s   = fill_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        pix_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (bus.req) begin
                    ox_s   = acc_ox_s;
                    oy_s   = acc_oy_s;
                    n_s    = acc_n_s;
                    fill_s = acc_fill_s;
                    col_s  = 6'd0;
                    row_s  = 6'd0;
                    busy_s = 1'b1;
                    if (valid_s) begin
                        state_s  = DRAW;
                        pix_en_s = 1'b1;
                    end else begin
                        // Nothing to draw: report completion straight away.
                        state_s = DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DRAW: begin
                busy_s = 1'b1;
                if ((col_r == n_r - 6'd1) && (row_r == n_r - 6'd1)) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    pix_en_s = 1'b1;
                    if (col_r == n_r - 6'd1) begin
                        col_s = 6'd0;
                        row_s = row_r + 6'd1;
                    end else begin
                        col_s = col_r + 6'd1;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase

        // Pixel for the coming cycle; off-screen pixels still take their slot.
        px_s   = ox_s + {3'b000, col_s};
        py_s   = oy_s + {2'b00, row_s};
        plot_s = pix_en_s && (px_s <= 9'd159) && (py_s <= 8'd119);
        if (pix_en_s) begin
            x_s      = px_s[7:0];
            y_s      = py_s[6:0];
            colour_s = fill_s;
        end else begin
            x_s      = x_r;
            y_s      = y_r;
            colour_s = colour_r;
        end
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            col_r    <= 6'd0;
            row_r    <= 6'd0;
            n_r      <= 6'd0;
            ox_r     <= 9'd0;
            oy_r     <= 8'd0;
            fill_r   <= 3'b000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            plot_r   <= 1'b0;
            x_r      <= 8'd0;
            y_r      <= 7'd0;
            colour_r <= 3'b000;
        end else begin
            state_r  <= state_s;
            col_r    <= col_s;
            row_r    <= row_s;
            n_r      <= n_s;
            ox_r     <= ox_s;
            oy_r     <= oy_s;
            fill_r   <= fill_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            plot_r   <= plot_s;
            x_r      <= x_s;
            y_r      <= y_s;
            colour_r <= colour_s;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.plot   = plot_r;
    assign bus.x      = x_r;
    assign bus.y      = y_r;
    assign bus.colour = colour_r;

endmodule
